// File: rtl/door_wait_timer_if.sv
// door_wait_timer_if
//   Bundles the control and status signals of the door wait timer.
//   master : the floor FSM / door-sensor side (drives requests, reads status)
//   slave  : the timer itself
//   Requests : tick_en, start, cfg_time, extend, hold, skip, abort, ack
//   Status   : busy, done, check_pulse, remaining, ext_limit
interface door_wait_timer_if #(
    parameter int CNT_W = 8
);
    logic             tick_en;
    logic             start;
    logic [CNT_W-1:0] cfg_time;
    logic             extend;
    logic             hold;
    logic             skip;
    logic             abort;
    logic             ack;
    logic             busy;
    logic             done;
    logic             check_pulse;
    logic [CNT_W-1:0] remaining;
    logic             ext_limit;

    modport master (
        output tick_en, start, cfg_time, extend, hold, skip, abort, ack,
        input  busy, done, check_pulse, remaining, ext_limit
    );

    modport slave (
        input  tick_en, start, cfg_time, extend, hold, skip, abort, ack,
        output busy, done, check_pulse, remaining, ext_limit
    );
endinterface

// File: rtl/door_wait_timer.sv
// door_wait_timer
//   Times door-open / dwell intervals for the elevator controller.
//   The interval is cfg_time (latched at start) or DEF_TIME when cfg_time is 0.
//   Counting advances only on tick_en cycles and can be frozen (hold),
//   reloaded a bounded number of times (extend), forced to expire (skip) or
//   cancelled (abort). done is a level held until ack / abort / restart.
// Ports
//   clk   : system clock, rising edge
//   rst_n : synchronous active-low reset
//   bus   : door_wait_timer_if.slave (requests in, status out)
module door_wait_timer #(
    parameter int CNT_W      = 8,
    parameter int DEF_TIME   = 5,
    parameter int CHECK_LEAD = 1,
    parameter int MAX_EXTEND = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    door_wait_timer_if.slave  bus
);
    localparam int EXT_W = (MAX_EXTEND > 0) ? $clog2(MAX_EXTEND + 1) : 1;
    localparam logic [CNT_W-1:0] DEF_VAL  = CNT_W'(DEF_TIME);
    localparam logic [CNT_W-1:0] LEAD_VAL = CNT_W'(CHECK_LEAD);
    localparam logic [EXT_W-1:0] EXT_MAX  = EXT_W'(MAX_EXTEND);

    typedef enum logic [1:0] {S_IDLE, S_COUNT, S_DONE} state_t;

    state_t           state_reg;
    logic [CNT_W-1:0] remaining_reg;
    logic [CNT_W-1:0] load_val_reg;
    logic [EXT_W-1:0] ext_cnt_reg;
    logic             check_pulse_reg;
    logic             ext_limit_reg;

    logic [CNT_W-1:0] start_val;
    logic [CNT_W-1:0] rem_dec;
    logic             ext_ok;

    assign start_val = (bus.cfg_time == '0) ? DEF_VAL : bus.cfg_time;
    assign rem_dec   = remaining_reg - CNT_W'(1);
    // With MAX_EXTEND=0, EXT_MAX is 0 and no extend is ever accepted.
    assign ext_ok    = bus.extend && (ext_cnt_reg < EXT_MAX);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg       <= S_IDLE;
            remaining_reg   <= '0;
            load_val_reg    <= '0;
            ext_cnt_reg     <= '0;
            check_pulse_reg <= 1'b0;
            ext_limit_reg   <= 1'b0;
        end else begin
            check_pulse_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (bus.start) begin
                        load_val_reg  <= start_val;
                        remaining_reg <= start_val;
                        ext_cnt_reg   <= '0;
                        ext_limit_reg <= 1'b0;
                        state_reg     <= S_COUNT;
                    end
                end
                S_COUNT: begin
                    if (bus.abort) begin
                        remaining_reg <= '0;
                        state_reg     <= S_IDLE;
                    end else if (bus.skip) begin
                        remaining_reg <= '0;
                        state_reg     <= S_DONE;
                    end else if (ext_ok) begin
                        remaining_reg <= load_val_reg;
                        ext_cnt_reg   <= ext_cnt_reg + EXT_W'(1);
                    end else begin
                        // A refused extend is recorded, then the cycle behaves
                        // as if extend were low.
                        if (bus.extend)
                            ext_limit_reg <= 1'b1;
                        if (!bus.hold && bus.tick_en) begin
                            if (remaining_reg <= CNT_W'(1)) begin
                                remaining_reg <= '0;
                                state_reg     <= S_DONE;
                            end else begin
                                remaining_reg <= rem_dec;
                                if ((CHECK_LEAD != 0) && (rem_dec == LEAD_VAL))
                                    check_pulse_reg <= 1'b1;
                            end
                        end
                    end
                end
                S_DONE: begin
                    if (bus.abort) begin
                        remaining_reg <= '0;
                        state_reg     <= S_IDLE;
                    end else if (bus.start) begin
                        load_val_reg  <= start_val;
                        remaining_reg <= start_val;
                        ext_cnt_reg   <= '0;
                        ext_limit_reg <= 1'b0;
                        state_reg     <= S_COUNT;
                    end else if (ext_ok) begin
                        // Door re-open after expiry: run the full interval again.
                        remaining_reg <= load_val_reg;
                        ext_cnt_reg   <= ext_cnt_reg + EXT_W'(1);
                        state_reg     <= S_COUNT;
                    end else if (bus.extend) begin
                        ext_limit_reg <= 1'b1;
                    end else if (bus.ack) begin
                        state_reg     <= S_IDLE;
                    end
                end
                default: begin
                    remaining_reg <= '0;
                    state_reg     <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy        = (state_reg == S_COUNT);
    assign bus.done        = (state_reg == S_DONE);
    assign bus.check_pulse = check_pulse_reg;
    assign bus.remaining   = remaining_reg;
    assign bus.ext_limit   = ext_limit_reg;
endmodule
